id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised decode stage with an ID/EX pipeline register. It owns the architectural register file and the immediate extender, and adds a valid/ready handshake, flush, and load-use bubble insertion. It also keeps a saturating stall counter. It sits between the IF/ID register and EX; the decoder's control bundle passes through it packed and opaque.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- REG_AW, 5, register address width; the file holds 2**REG_AW entries and entry 0 is hardwired zero
- CTRL_W, 16, width of the packed control bundle
- MEMREAD_BIT, 3, index of the mem-read flag within the control bundle

Ports (clock `clk`, reset `reset`; one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream holds an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc_plus_4  in  DATA_W  PC+4 of the instruction
- in_ctrl  in  CTRL_W  decoded control bundle
- in_ext_op  in  1  1 = sign-extend imm16, 0 = zero-extend
- in_lu_op  in  1  1 = imm16 placed in the upper half, lower half zero
- wb_we  in  1  writeback enable
- wb_addr  in  REG_AW  writeback register
- wb_data  in  DATA_W  writeback data
- flush  in  1  kill the current and incoming instruction
- out_valid  out  1  EX payload valid
- out_ready  in  1  EX accepts
- out_ctrl  out  CTRL_W  registered control bundle
- out_pc_plus_4  out  DATA_W  registered PC+4
- out_rs_data, out_rt_data  out  DATA_W  register operands
- out_imm  out  DATA_W  extended immediate
- out_rs, out_rt, out_rd  out  REG_AW  instruction fields [25:21], [20:16], [15:11], zero-extended or truncated to REG_AW
- out_shamt  out  DATA_W  {zeros, inst[10:6]}
- stall_cnt  out  32  number of load-use bubbles inserted, saturating

## Operation
- Operand read:
  - The register file is read combinationally at inst[25:21] and inst[20:16].
  - Reading address 0 returns 0.
  - A write is committed on the clk edge when wb_we=1 and wb_addr≠0.
- Immediate:
  - in_lu_op=1 gives {imm16, 16'b0}.
  - Otherwise in_ext_op selects sign- or zero-extension to DATA_W.
- Hazard:
  - hz = out_valid & out_ctrl[MEMREAD_BIT] & in_valid & (out_rt≠0) & (out_rt==rs_field | out_rt==rt_field).
  - The comparison is conservative: both fields are compared regardless of instruction type.
- Handshake:
  - adv = ~out_valid | out_ready.
  - in_ready = adv & ~hz, or flush=1.
  - Transfer occurs when in_valid & in_ready & ~flush.
- Register update, in priority order:
  1. reset: all registers cleared.
  2. flush: out_valid←0; the incoming instruction is consumed and dropped; payload registers hold.
  3. adv & hz: bubble. out_valid←0, stall_cnt+1 (saturates at 0xFFFF_FFFF), upstream held.
  4. transfer: all payload registers load and out_valid←1.
  5. adv without transfer: out_valid←0.
  6. otherwise: hold everything.
- Payload registers change only on a transfer. During a stall they keep their previous values.

## Timing
- Reset value of every output register is 0, including out_valid and stall_cnt.
- The register file is cleared to 0 on reset.
- in_ready is combinational.
- Latency is one cycle: an instruction transferred at edge N is presented at out_* after edge N.
- Throughput is one instruction per cycle when out_ready=1 and there is no hazard.
- A load-use pair costs exactly one bubble cycle. After the bubble, out_valid=0, so hz clears and the consumer transfers on the next edge.
- Simultaneous flush and hazard: flush wins and stall_cnt does not increment.
- Simultaneous wb write and read of the same register: see Configuration.
- Reset asserted mid-stall: everything clears on that edge, and the pending upstream instruction must be re-presented.

## Configuration
- ID_BYPASS_EN defined:
  - When wb_we=1 and wb_addr is nonzero and matches a read address in the same cycle, the read returns wb_data (write-first).
  - The bypassed value is what gets registered into out_rs_data / out_rt_data.
- ID_BYPASS_EN undefined:
  - Reads return the stored value (read-first).
  - The newly written value is visible from the next cycle onward.

## Test plan
- Reset, then write r5=0x1234 through WB, then transfer an instruction with rs=5, rt=0 -> out_rs_data=0x1234, out_rt_data=0, out_valid=1 one cycle after transfer.
- Immediate 0x8001: ext_op=1 -> 0xFFFF8001; ext_op=0 -> 0x00008001; lu_op=1 -> 0x80010000.
- Load writing rt=8 in EX stage (ctrl[MEMREAD_BIT]=1), consumer with rs=8 presented -> in_ready=0 for one cycle, then one cycle with out_valid=0, stall_cnt=1, then the consumer appears.
- out_ready=0 for 3 cycles while valid -> out_* stable and in_ready=0; on release the next instruction transfers.
- Same-cycle WB write r9=0xCAFE with a read of r9 -> 0xCAFE with ID_BYPASS_EN, the old value without it; a write to r0 always reads back 0.
- flush asserted together with in_valid and a hazard -> in_ready=1, out_valid=0 next cycle, stall_cnt unchanged.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage with register file, immediate extender and the
// ID/EX pipeline register. Inserts one bubble on a load-use hazard and keeps
// a saturating count of those bubbles.
// Optional macro ID_BYPASS_EN: same-cycle writeback is forwarded to the
// operand reads (write-first). Without it reads are read-first.
//
// Handshake: a beat moves upstream->stage when in_valid & in_ready & ~flush,
// and stage->EX when out_valid & out_ready. in_ready never depends on
// in_valid except through the hazard term; flush forces in_ready so the
// incoming instruction is consumed and dropped.
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int CTRL_W      = 16,
    parameter int MEMREAD_BIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_pc_plus_4,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_ext_op,
    input  logic              in_lu_op,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_pc_plus_4,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_shamt,
    output logic [31:0]       stall_cnt
);
    localparam int DEPTH = 1 << REG_AW;

    logic [DATA_W-1:0] rf [DEPTH];

    logic [REG_AW-1:0] rs_a, rt_a, rd_a;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] rs_data, rt_data, imm, shamt;
    logic              hz, adv, transfer;
    logic              unused_opcode;

    assign rs_a          = REG_AW'(in_inst[25:21]);
    assign rt_a          = REG_AW'(in_inst[20:16]);
    assign rd_a          = REG_AW'(in_inst[15:11]);
    assign imm16         = in_inst[15:0];
    assign shamt         = DATA_W'(in_inst[10:6]);
    assign unused_opcode = ^in_inst[31:26];

    // Operand read; entry 0 always reads as zero.
    always_comb begin
        rs_data = rf[rs_a];
        rt_data = rf[rt_a];
`ifdef ID_BYPASS_EN
        if (wb_we && (wb_addr != '0) && (wb_addr == rs_a)) rs_data = wb_data;
        if (wb_we && (wb_addr != '0) && (wb_addr == rt_a)) rt_data = wb_data;
`endif
        if (rs_a == '0) rs_data = '0;
        if (rt_a == '0) rt_data = '0;
    end

    // Immediate extender: upper placement wins over sign/zero extension.
    always_comb begin
        imm = '0;
        if (in_lu_op)
            imm = DATA_W'({imm16, 16'b0});
        else if (in_ext_op)
            imm = {{(DATA_W-16){imm16[15]}}, imm16};
        else
            imm = {{(DATA_W-16){1'b0}}, imm16};
    end

    // Load in EX whose destination feeds either source field of the incoming
    // instruction. Both fields are compared regardless of instruction type.
    assign hz = out_valid & out_ctrl[MEMREAD_BIT] & in_valid & (out_rt != '0)
              & ((out_rt == rs_a) | (out_rt == rt_a));
    assign adv      = ~out_valid | out_ready;
    assign in_ready = (adv & ~hz) | flush;
    assign transfer = in_valid & in_ready & ~flush;

    // Register file: cleared on reset, entry 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // ID/EX register: flush, then bubble, then transfer, then drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_ctrl      <= '0;
            out_pc_plus_4 <= '0;
            out_rs_data   <= '0;
            out_rt_data   <= '0;
            out_imm       <= '0;
            out_rs        <= '0;
            out_rt        <= '0;
            out_rd        <= '0;
            out_shamt     <= '0;
            stall_cnt     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv && hz) begin
            out_valid <= 1'b0;
            if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        end else if (transfer) begin
            out_valid     <= 1'b1;
            out_ctrl      <= in_ctrl;
            out_pc_plus_4 <= in_pc_plus_4;
            out_rs_data   <= rs_data;
            out_rt_data   <= rt_data;
            out_imm       <= imm;
            out_rs        <= rs_a;
            out_rt        <= rt_a;
            out_rd        <= rd_a;
            out_shamt     <= shamt;
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the decode stage.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc_plus_4 = '0;
    logic [15:0] in_ctrl = '0;
    logic        in_ext_op = 1'b0;
    logic        in_lu_op = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_ctrl;
    logic [31:0] out_pc_plus_4, out_rs_data, out_rt_data, out_imm, out_shamt;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc_plus_4(in_pc_plus_4), .in_ctrl(in_ctrl),
        .in_ext_op(in_ext_op), .in_lu_op(in_lu_op),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_pc_plus_4(out_pc_plus_4), .out_rs_data(out_rs_data),
        .out_rt_data(out_rt_data), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .stall_cnt(stall_cnt)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [15:0] m_ctrl;
    logic [31:0] m_pc, m_rs_d, m_rt_d, m_imm, m_shamt, m_stall;
    logic [4:0]  m_rs, m_rt, m_rd;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    function automatic logic [31:0] m_ext(input logic [15:0] v, input logic ext, input logic lu);
        logic [31:0] r;
        if (lu) r = 32'(v) * 32'h1_0000;
        else if (ext && v >= 16'h8000) r = 32'(v) + 32'hFFFF_0000;
        else r = 32'(v);
        return r;
    endfunction

    function automatic logic m_hazard();
        logic [4:0] s, t;
        s = in_inst[25:21];
        t = in_inst[20:16];
        return m_valid && m_ctrl[3] && in_valid && m_rt != 0 && (m_rt == s || m_rt == t);
    endfunction

    function automatic logic m_ready();
        return ((!m_valid || out_ready) && !m_hazard()) || flush;
    endfunction

    task automatic model_update();
        logic adv, hz;
        adv = !m_valid || out_ready;
        hz  = m_hazard();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs_d = 0; m_rt_d = 0;
            m_imm = 0; m_shamt = 0; m_stall = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        end else begin
            if (flush) m_valid = 0;
            else if (adv && hz) begin
                m_valid = 0;
                if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            end else if (in_valid && m_ready()) begin
                m_valid = 1;
                m_ctrl  = in_ctrl;
                m_pc    = in_pc_plus_4;
                m_rs    = in_inst[25:21];
                m_rt    = in_inst[20:16];
                m_rd    = in_inst[15:11];
                m_rs_d  = m_read(in_inst[25:21]);
                m_rt_d  = m_read(in_inst[20:16]);
                m_imm   = m_ext(in_inst[15:0], in_ext_op, in_lu_op);
                m_shamt = 32'(in_inst[10:6]);
            end else if (adv) m_valid = 0;
            if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
        chk("out_pc_plus_4", out_pc_plus_4, m_pc);
        chk("out_rs_data", out_rs_data, m_rs_d);
        chk("out_rt_data", out_rt_data, m_rt_d);
        chk("out_imm", out_imm, m_imm);
        chk("out_shamt", out_shamt, m_shamt);
        chk("out_rs", 32'(out_rs), 32'(m_rs));
        chk("out_rt", 32'(out_rt), 32'(m_rt));
        chk("out_rd", 32'(out_rd), 32'(m_rd));
    endtask

    // one clock: check combinational in_ready, advance, check registers
    task automatic step();
        #1;
        if (!reset) chk("in_ready", 32'(in_ready), 32'(m_ready()));
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    // ---------------- drivers ----------------
    function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    task automatic present(input logic [31:0] inst, input logic [31:0] pc,
                           input logic [15:0] ctrl, input logic ext, input logic lu);
        in_valid = 1; in_inst = inst; in_pc_plus_4 = pc;
        in_ctrl = ctrl; in_ext_op = ext; in_lu_op = lu;
    endtask

    task automatic idle();
        in_valid = 0; wb_we = 0; flush = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] exp_byp;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs_d = 0; m_rt_d = 0;
        m_imm = 0; m_shamt = 0; m_stall = 0; m_rs = 0; m_rt = 0; m_rd = 0;

        // reset
        reset = 1; step(); step();
        reset = 0;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_stall", stall_cnt, 32'd0);

        // write r5 then read it
        wb_we = 1; wb_addr = 5; wb_data = 32'h1234; step();
        wb_we = 0;
        present(mk_inst(5, 0, 16'h0000), 32'h0000_0104, 16'h0000, 0, 0); step();
        chk("lit_rs_r5", out_rs_data, 32'h1234);
        chk("lit_rt_r0", out_rt_data, 32'h0);
        chk("lit_valid_1", 32'(out_valid), 32'd1);

        // immediates
        present(mk_inst(1, 2, 16'h8001), 32'h108, 16'h0, 1, 0); step();
        chk("lit_imm_sext", out_imm, 32'hFFFF_8001);
        present(mk_inst(1, 2, 16'h8001), 32'h10C, 16'h0, 0, 0); step();
        chk("lit_imm_zext", out_imm, 32'h0000_8001);
        present(mk_inst(1, 2, 16'h8001), 32'h110, 16'h0, 1, 1); step();
        chk("lit_imm_lui", out_imm, 32'h8001_0000);

        // load-use: load writes r8, consumer reads r8
        present(mk_inst(1, 8, 16'h0), 32'h114, 16'h0008, 0, 0); step();
        present(mk_inst(8, 3, 16'h0), 32'h118, 16'h0000, 0, 0);
        #1 chk("lit_hz_ready", 32'(in_ready), 32'd0);
        step();
        chk("lit_bubble_valid", 32'(out_valid), 32'd0);
        chk("lit_stall_1", stall_cnt, 32'd1);
        step();
        chk("lit_consumer_pc", out_pc_plus_4, 32'h118);
        chk("lit_consumer_valid", 32'(out_valid), 32'd1);
        idle(); step();

        // EX backpressure for three cycles
        present(mk_inst(2, 3, 16'h0), 32'h200, 16'h0, 0, 0); step();
        present(mk_inst(4, 5, 16'h0), 32'h204, 16'h0, 0, 0); out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_hold_pc", out_pc_plus_4, 32'h200);
        end
        out_ready = 1; step();
        chk("lit_release_pc", out_pc_plus_4, 32'h204);
        idle(); step();

        // same-cycle writeback/read of r9, then r0
        wb_we = 1; wb_addr = 9; wb_data = 32'h1111; step();
        wb_data = 32'hCAFE;
        present(mk_inst(9, 9, 16'h0), 32'h300, 16'h0, 0, 0); step();
`ifdef ID_BYPASS_EN
        exp_byp = 32'hCAFE;
`else
        exp_byp = 32'h1111;
`endif
        chk("lit_same_cycle_r9", out_rs_data, exp_byp);
        wb_addr = 0; wb_data = 32'hFFFF;
        present(mk_inst(0, 0, 16'h0), 32'h304, 16'h0, 0, 0); step();
        wb_we = 0; step();
        chk("lit_r0_zero", out_rs_data, 32'h0);
        idle(); step();

        // flush together with a hazard
        present(mk_inst(1, 8, 16'h0), 32'h400, 16'h0008, 0, 0); step();
        present(mk_inst(8, 8, 16'h0), 32'h404, 16'h0, 0, 0); flush = 1;
        #1 chk("lit_flush_ready", 32'(in_ready), 32'd1);
        step();
        chk("lit_flush_valid", 32'(out_valid), 32'd0);
        chk("lit_flush_stall", stall_cnt, 32'd1);
        idle(); step();

        // reset while a load-use hazard is pending
        present(mk_inst(1, 8, 16'h0), 32'h500, 16'h0008, 0, 0); step();
        present(mk_inst(8, 0, 16'h0), 32'h504, 16'h0, 0, 0); reset = 1; step();
        reset = 0;
        chk("lit_reset_stall", stall_cnt, 32'd0);
        present(mk_inst(5, 0, 16'h0), 32'h508, 16'h0, 0, 0); step();
        chk("lit_rf_cleared", out_rs_data, 32'h0);
        idle(); step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] inst;
            inst = $urandom;
            inst[25:21] = 5'($urandom_range(0, 7));
            inst[20:16] = 5'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_we     = $urandom_range(0, 1) == 1;
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = inst;
            in_pc_plus_4 = $urandom;
            in_ctrl   = 16'($urandom);
            in_ctrl[3] = $urandom_range(0, 1) == 1;
            in_ext_op = $urandom_range(0, 1) == 1;
            in_lu_op  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
